// File: rtl/trace_frame_tx.sv
// Serial trace transmitter. Snapshots the debug state on a trigger and shifts it out as a
// 13-byte frame (header, 11 payload bytes, XOR checksum), 10 bits per byte, idle-high line.
module trace_frame_tx #(
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] pc,
    input  logic [7:0] ir,
    input  logic [7:0] pm_address,
    input  logic [7:0] from_PS,
    input  logic [7:0] from_ID,
    input  logic [7:0] from_CU,
    input  logic [3:0] o_reg,
    input  logic [3:0] x0,
    input  logic [3:0] x1,
    input  logic [3:0] y0,
    input  logic [3:0] y1,
    input  logic [3:0] r,
    input  logic [3:0] m,
    input  logic [3:0] i,
    input  logic       zero_flag,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] dropped_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [3:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    snap_q [12];
    logic [7:0]    snap_d [12];
    logic [7:0]    cap    [12];
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    cur_byte;

    // Payload bytes B1..B11 and checksum B12, stored at index 0..11.
    always_comb begin
        cap[0]  = pc;
        cap[1]  = ir;
        cap[2]  = pm_address;
        cap[3]  = from_PS;
        cap[4]  = from_ID;
        cap[5]  = from_CU;
        cap[6]  = {m, o_reg};
        cap[7]  = {x1, x0};
        cap[8]  = {y1, y0};
        cap[9]  = {i, r};
        cap[10] = {7'b0, zero_flag};
        cap[11] = 8'h00;
        for (int k = 0; k < 11; k++) begin
            cap[11] = cap[11] ^ cap[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        done_d     = 1'b0;
        drop_d     = drop_q;
        cur_byte   = HEADER;
        tx_d       = 1'b1;

        if (trigger && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        if (state_q == ST_IDLE) begin
            if (trigger) begin
                snap_d     = cap;
                state_d    = ST_START;
                bit_cnt_d  = '0;
                bit_idx_d  = 3'd0;
                byte_idx_d = 4'd0;
            end
        end else if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            case (state_q)
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
                ST_DATA: begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                default: begin
                    if (byte_idx_q == 4'd12) begin
                        state_d    = ST_IDLE;
                        byte_idx_d = 4'd0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
            endcase
        end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
        end

        // Line level is derived from the next state so tx_out stays a plain register.
        if (byte_idx_d != 4'd0) begin
            cur_byte = snap_q[byte_idx_d - 4'd1];
        end
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = cur_byte[bit_idx_d];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 4'd0;
            for (int k = 0; k < 12; k++) begin
                snap_q[k] <= 8'h00;
            end
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_out        = tx_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_trace_frame_tx.sv
// Bench for trace_frame_tx: two instances (4 and 1 clocks per bit), per-cycle line check
// against a bit stream built from the captured input values.
module tb_trace_frame_tx;

    logic       clk = 1'b0;
    logic       reset, trig, sel;
    logic [7:0] pc, ir, pm, fps, fid, fcu;
    logic [3:0] o_reg, x0, x1, y0, y1, r, m, i_n;
    logic       zf;

    logic       trig4, trig1;
    logic       tx4, busy4, done4, tx1, busy1, done1;
    logic [7:0] drop4, drop1;
    logic       tx_m, busy_m, done_m;
    logic [7:0] drop_m;

    int n_chk = 0;
    int n_fail = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    assign trig4  = trig & ~sel;
    assign trig1  = trig & sel;
    assign tx_m   = sel ? tx1 : tx4;
    assign busy_m = sel ? busy1 : busy4;
    assign done_m = sel ? done1 : done4;
    assign drop_m = sel ? drop1 : drop4;

    trace_frame_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut4 (
        .clk(clk), .reset(reset), .trigger(trig4),
        .pc(pc), .ir(ir), .pm_address(pm), .from_PS(fps), .from_ID(fid), .from_CU(fcu),
        .o_reg(o_reg), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i_n),
        .zero_flag(zf), .tx_out(tx4), .busy(busy4), .frame_done(done4), .dropped_count(drop4)
    );

    trace_frame_tx #(.CLKS_PER_BIT(1), .HEADER(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .trigger(trig1),
        .pc(pc), .ir(ir), .pm_address(pm), .from_PS(fps), .from_ID(fid), .from_CU(fcu),
        .o_reg(o_reg), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i_n),
        .zero_flag(zf), .tx_out(tx1), .busy(busy1), .frame_done(done1), .dropped_count(drop1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        {pc, ir, pm, fps, fid, fcu} = '0;
        {o_reg, x0, x1, y0, y1, r, m, i_n} = '0;
        zf = 1'b0;
    endtask

    task automatic rand_inputs();
        pc = 8'($urandom); ir = 8'($urandom); pm = 8'($urandom);
        fps = 8'($urandom); fid = 8'($urandom); fcu = 8'($urandom);
        o_reg = 4'($urandom); x0 = 4'($urandom); x1 = 4'($urandom); y0 = 4'($urandom);
        y1 = 4'($urandom); r = 4'($urandom); m = 4'($urandom); i_n = 4'($urandom);
        zf = 1'($urandom);
    endtask

    // Expected line: 13 bytes, each as start 0, 8 data bits LSB first, stop 1.
    task automatic build_stream(output logic [129:0] s);
        logic [7:0] b [13];
        b[0] = 8'hA5; b[1] = pc; b[2] = ir; b[3] = pm; b[4] = fps; b[5] = fid; b[6] = fcu;
        b[7] = {m, o_reg}; b[8] = {x1, x0}; b[9] = {y1, y0}; b[10] = {i_n, r};
        b[11] = {7'b0, zf};
        b[12] = 8'h00;
        for (int k = 1; k <= 11; k++) b[12] = b[12] ^ b[k];
        for (int k = 0; k < 13; k++) begin
            s[10*k] = 1'b0;
            for (int j = 0; j < 8; j++) s[10*k+1+j] = b[k][j];
            s[10*k+9] = 1'b1;
        end
    endtask

    // mode: 0 trigger pulse only, 1 hold trigger, 2 random triggers while busy.
    task automatic run_frame(input int mode, input bit scramble, input bit chain, input int abort_at);
        logic [129:0] s;
        int cpb;
        int len;
        cpb = sel ? 1 : 4;
        len = 130 * cpb;
        build_stream(s);
        trig = 1'b1;
        @(negedge clk);
        trig = (mode == 1);
        if (scramble) rand_inputs();
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                trig  = 1'b0;
                @(negedge clk);
                check_eq("abort_tx", tx_m, 1);
                check_eq("abort_busy", busy_m, 0);
                check_eq("abort_done", done_m, 0);
                check_eq("abort_drop", drop_m, 0);
                reset = 1'b0;
                exp_drop = 0;
                @(negedge clk);
                check_eq("abort_done2", done_m, 0);
                check_eq("abort_tx2", tx_m, 1);
                check_eq("abort_busy2", busy_m, 0);
                return;
            end
            check_eq("tx", tx_m, s[k/cpb]);
            check_eq("busy", busy_m, 1);
            check_eq("done_early", done_m, 0);
            if (mode == 2) trig = ($urandom_range(0, 9) == 0);
            if (chain && k == len - 1) trig = 1'b1;
            if (trig && exp_drop < 255) exp_drop++;
            @(negedge clk);
        end
        check_eq("done", done_m, 1);
        check_eq("busy_end", busy_m, 0);
        check_eq("tx_end", tx_m, 1);
        check_eq("dropped", drop_m, exp_drop);
        if (!chain && mode != 1) trig = 1'b0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_eq("idle_done", done_m, 0);
        check_eq("idle_busy", busy_m, 0);
        check_eq("idle_tx", tx_m, 1);
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        trig = 1'b0;
        zero_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst_tx4", tx4, 1);
        check_eq("rst_busy4", busy4, 0);
        check_eq("rst_done4", done4, 0);
        check_eq("rst_drop4", drop4, 0);
        check_eq("rst_tx1", tx1, 1);
        check_eq("rst_busy1", busy1, 0);
        check_eq("rst_done1", done1, 0);
        check_eq("rst_drop1", drop1, 0);
        reset = 1'b0;
        idle_check();

        // all-zero frame, then a small known pattern
        run_frame(0, 0, 0, -1);
        idle_check();
        zero_inputs();
        pc = 8'h01; ir = 8'h02; zf = 1'b1;
        run_frame(0, 0, 0, -1);
        idle_check();

        // random frames, inputs changed after capture, stray triggers while busy
        for (int n = 0; n < 3; n++) begin
            rand_inputs();
            run_frame(2, 1, 0, -1);
            idle_check();
        end

        // held trigger saturates the drop count; next frame starts the edge after done
        rand_inputs();
        run_frame(1, 0, 0, -1);
        rand_inputs();
        run_frame(0, 0, 0, -1);
        check_eq("drop_sat", drop4, 8'hFF);
        idle_check();

        // reset during byte 6 aborts; a full frame follows
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        rand_inputs();
        run_frame(2, 0, 0, 60 * 4 + 5);
        rand_inputs();
        run_frame(0, 0, 0, -1);
        idle_check();

        // one clock per bit, trigger on the frame_done edge is dropped then accepted next edge
        sel = 1'b1;
        exp_drop = 0;
        rand_inputs();
        run_frame(0, 0, 1, -1);
        rand_inputs();
        run_frame(0, 0, 0, -1);
        check_eq("drop_chain", drop1, 1);
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
